// File: rtl/featuremap_sched.sv
// One conv1 feature map: routes interleaved c0/c1/c2 samples to the three
// channel instances, sums their results with the bias, applies ReLU/saturation.
module featuremap_sched #(
    parameter int                            DATA_WIDTH = 24,
    parameter int                            IMG_W      = 32,
    parameter int                            IMG_H      = 32,
    parameter logic signed [DATA_WIDTH-1:0]  BIAS       = '0,
    parameter bit                            RELU       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_sof,
    output logic [DATA_WIDTH-1:0] conv_data,
    output logic [2:0]            conv_valid,
    input  logic [DATA_WIDTH-1:0] conv_out0,
    input  logic [DATA_WIDTH-1:0] conv_out1,
    input  logic [DATA_WIDTH-1:0] conv_out2,
    input  logic [2:0]            conv_vout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  frame_done,
    output logic                  err
);

    localparam int SUM_W = DATA_WIDTH + 2;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {CH0, CH1, CH2} in_state_t;
    typedef enum logic [1:0] {ACC0, ACC1, ACC2} acc_state_t;

    function automatic logic signed [DATA_WIDTH-1:0] f_relu_sat(input logic signed [SUM_W-1:0] sum);
        if (RELU && sum[SUM_W-1])
            return '0;
        else if (sum > SAT_MAX)
            return SAT_MAX[DATA_WIDTH-1:0];
        else if (sum < SAT_MIN)
            return SAT_MIN[DATA_WIDTH-1:0];
        else
            return sum[DATA_WIDTH-1:0];
    endfunction

    in_state_t                     r_in_state, w_in_next;
    acc_state_t                    r_acc_state, w_acc_next;
    logic [2:0]                    w_cv_next;
    logic                          w_sof_err, w_col_err, w_cap0, w_cap1, w_done, w_vout_multi;
    logic signed [DATA_WIDTH-1:0]  r_p0, r_p1;
    logic signed [SUM_W-1:0]       w_sum;
    logic [COL_W-1:0]              r_col;
    logic [ROW_W-1:0]              r_row;
    logic                          w_last_col, w_last_row, w_in_win;

    always_comb begin
        w_in_next = r_in_state;
        w_cv_next = 3'b000;
        w_sof_err = 1'b0;
        if (s_valid) begin
            if (s_sof) begin
                w_cv_next = 3'b001;
                w_in_next = CH1;
                w_sof_err = (r_in_state != CH0);
            end else begin
                case (r_in_state)
                    CH0: begin w_cv_next = 3'b001; w_in_next = CH1; end
                    CH1: begin w_cv_next = 3'b010; w_in_next = CH2; end
                    CH2: begin w_cv_next = 3'b100; w_in_next = CH0; end
                    default: w_in_next = CH0;
                endcase
            end
        end
    end

    // Out-of-order or simultaneous valid_out bits are flagged and dropped.
    assign w_vout_multi = (conv_vout & (conv_vout - 3'd1)) != 3'd0;

    always_comb begin
        w_acc_next = r_acc_state;
        w_cap0     = 1'b0;
        w_cap1     = 1'b0;
        w_done     = 1'b0;
        w_col_err  = 1'b0;
        if (conv_vout != 3'b000) begin
            if (w_vout_multi) begin
                w_col_err = 1'b1;
            end else begin
                case (r_acc_state)
                    ACC0: if (conv_vout == 3'b001) begin w_cap0 = 1'b1; w_acc_next = ACC1; end
                          else w_col_err = 1'b1;
                    ACC1: if (conv_vout == 3'b010) begin w_cap1 = 1'b1; w_acc_next = ACC2; end
                          else w_col_err = 1'b1;
                    ACC2: if (conv_vout == 3'b100) begin w_done = 1'b1; w_acc_next = ACC0; end
                          else w_col_err = 1'b1;
                    default: w_acc_next = ACC0;
                endcase
            end
        end
    end

    assign w_sum = {{2{r_p0[DATA_WIDTH-1]}}, r_p0}
                 + {{2{r_p1[DATA_WIDTH-1]}}, r_p1}
                 + {{2{conv_out2[DATA_WIDTH-1]}}, conv_out2}
                 + {{2{BIAS[DATA_WIDTH-1]}}, BIAS};

    assign w_last_col = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
    assign w_in_win   = (r_col >= COL_W'(4)) && (r_row >= ROW_W'(4));

    always_ff @(posedge clk) begin
        if (w_cap0) r_p0 <= conv_out0;
        if (w_cap1) r_p1 <= conv_out1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_state  <= CH0;
            r_acc_state <= ACC0;
            conv_data   <= '0;
            conv_valid  <= 3'b000;
            m_data      <= '0;
            m_valid     <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
        end else begin
            r_in_state  <= w_in_next;
            r_acc_state <= w_acc_next;
            conv_valid  <= w_cv_next;
            if (s_valid) conv_data <= s_data;
            err         <= err | w_sof_err | w_col_err;
            m_valid     <= w_done && w_in_win;
            frame_done  <= w_done && w_last_col && w_last_row;
            if (w_done && w_in_win) m_data <= f_relu_sat(w_sum);
            // Raster position of the pixel being completed.
            if (w_done) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_featuremap_sched.sv
// Bench for featuremap_sched: four ReLU/bias variants run in lockstep behind
// 3-cycle echo stubs, checked every cycle against a pixel-level model.
module tb_featuremap_sched;

    localparam int DW = 24;
    localparam int W  = 8;
    localparam int H  = 8;

    typedef struct packed {
        logic [3:0][DW-1:0] v;
        logic               fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          inj_en = 1'b0;
    logic [2:0]    inj_vout = 3'b000;

    wire [DW-1:0] cdat [4];
    wire [2:0]    cval [4];
    wire [DW-1:0] mdat [4];
    wire          mval [4];
    wire          fdone [4];
    wire          errf [4];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam bit RG = (g % 2 == 0);
            localparam logic signed [DW-1:0] BG = (g >= 2) ? -24'sd5 : 24'sd0;
            logic [2:0]    sv0, sv1, sv2;
            logic [DW-1:0] sd0, sd1, sd2;
            logic [2:0]    vout;

            always @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sv0 <= '0; sv1 <= '0; sv2 <= '0;
                    sd0 <= '0; sd1 <= '0; sd2 <= '0;
                end else begin
                    sv0 <= cval[g]; sd0 <= cdat[g];
                    sv1 <= sv0;     sd1 <= sd0;
                    sv2 <= sv1;     sd2 <= sd1;
                end
            end
            assign vout = inj_en ? inj_vout : sv2;

            featuremap_sched #(
                .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .BIAS(BG), .RELU(RG)
            ) dut (
                .clk(clk), .rst(rst),
                .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
                .conv_data(cdat[g]), .conv_valid(cval[g]),
                .conv_out0(sd2), .conv_out1(sd2), .conv_out2(sd2),
                .conv_vout(vout),
                .m_data(mdat[g]), .m_valid(mval[g]), .frame_done(fdone[g]), .err(errf[g])
            );
        end
    endgenerate

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Pixel-level model: signed sum plus bias, optional clamp at zero, saturate to DW bits.
    function automatic logic [DW-1:0] mdl(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [DW-1:0] c, input int g);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c)) + ((g >= 2) ? -5 : 0);
        if ((g % 2 == 0) && s < 0) s = 0;
        else if (s > 64'sd8388607) s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
        return s[DW-1:0];
    endfunction

    int            mdl_ch = 0;
    int            mdl_pix = 0;
    exp_t          expq [$];
    logic [2:0]    exp_cv_drv = '0, exp_cv_q;
    logic [DW-1:0] exp_cd_drv = '0, exp_cd_q;
    logic          exp_err_drv = 1'b0, exp_err_q;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_cv_q  <= '0;
            exp_cd_q  <= '0;
            exp_err_q <= 1'b0;
        end else begin
            exp_cv_q  <= exp_cv_drv;
            if (exp_cv_drv != 3'b000) exp_cd_q <= exp_cd_drv;
            exp_err_q <= exp_err_drv;
        end
    end

    int            tot = 0;
    int            nfd = 0;
    logic [DW-1:0] rec [4][256];

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int g = 0; g < 4; g++) begin
                chk("rst_conv_data", 64'(cdat[g]), 64'd0);
                chk("rst_conv_valid", 64'(cval[g]), 64'd0);
                chk("rst_m_data", 64'(mdat[g]), 64'd0);
                chk("rst_m_valid", 64'(mval[g]), 64'd0);
                chk("rst_frame_done", 64'(fdone[g]), 64'd0);
                chk("rst_err", 64'(errf[g]), 64'd0);
            end
        end else begin
            for (int g = 0; g < 4; g++) begin
                chk("conv_valid", 64'(cval[g]), 64'(exp_cv_q));
                if (exp_cv_q != 3'b000) chk("conv_data", 64'(cdat[g]), 64'(exp_cd_q));
                chk("err", 64'(errf[g]), 64'(exp_err_q));
            end
            if (mval[0] || mval[1] || mval[2] || mval[3]) begin
                if (expq.size() == 0) begin
                    chk("m_valid_unexpected", 64'({mval[0], mval[1], mval[2], mval[3]}), 64'd0);
                end else begin
                    e = expq.pop_front();
                    for (int g = 0; g < 4; g++) begin
                        chk("m_valid", 64'(mval[g]), 64'd1);
                        chk("m_data", 64'(mdat[g]), 64'(e.v[g]));
                        chk("frame_done", 64'(fdone[g]), 64'(e.fd));
                        if (tot < 256) rec[g][tot] = mdat[g];
                    end
                    tot++;
                    if (fdone[0]) nfd++;
                end
            end else begin
                for (int g = 0; g < 4; g++) chk("frame_done_idle", 64'(fdone[g]), 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            s_valid = 1'b0; s_sof = 1'b0; exp_cv_drv = 3'b000;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic sof);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = d; s_sof = sof; exp_cd_drv = d;
        if (sof) begin
            if (mdl_ch != 0) exp_err_drv = 1'b1;
            exp_cv_drv = 3'b001;
            mdl_ch = 1;
        end else begin
            exp_cv_drv = 3'(1 << mdl_ch);
            mdl_ch = (mdl_ch + 1) % 3;
        end
    endtask

    task automatic send_pixel(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic sof);
        exp_t e;
        send(a, sof); send(b, 1'b0); send(c, 1'b0);
        if ((mdl_pix % W) >= 4 && (mdl_pix / W) >= 4) begin
            for (int g = 0; g < 4; g++) e.v[g] = mdl(a, b, c, g);
            e.fd = (mdl_pix == W * H - 1);
            expq.push_back(e);
        end
        mdl_pix = (mdl_pix + 1) % (W * H);
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0; inj_en = 1'b0; inj_vout = 3'b000;
        exp_cv_drv = 3'b000; exp_err_drv = 1'b0; mdl_ch = 0; mdl_pix = 0;
        expq.delete();
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic inject(input logic [2:0] v);
        @(posedge clk); #1;
        inj_en = 1'b1; inj_vout = v;
        if (v != 3'b000) exp_err_drv = 1'b1;
    endtask

    task automatic frame_checks(input string nm, input int base, input int fd0);
        chk({nm, "_count"}, 64'(tot - base), 64'd16);
        chk({nm, "_fdone"}, 64'(nfd - fd0), 64'd1);
        chk({nm, "_drain"}, 64'(expq.size()), 64'd0);
    endtask

    initial begin
        int base, fd0;
        logic [DW-1:0] a, b, c;
        #1 rst = 1'b0;
        apply_reset(3);

        // Frame 1: all-ones stream
        base = tot; fd0 = nfd;
        for (int p = 0; p < W * H; p++) send_pixel(24'd1, 24'd1, 24'd1, p == 0);
        idle(12);
        frame_checks("f1", base, fd0);
        chk("f1_lit_relu_b0", 64'(rec[0][base + 15]), 64'h3);
        chk("f1_lit_relu_bm5", 64'(rec[2][base]), 64'h0);
        chk("f1_lit_norelu_bm5", 64'(rec[3][base]), 64'hFFFFFE);

        // Frame 2: saturation and bias corners at the first window pixels
        base = tot; fd0 = nfd;
        for (int p = 0; p < W * H; p++) begin
            if (p == 4 * W + 4) begin a = 24'h7FFFFF; b = 24'h7FFFFF; c = 24'd1; end
            else if (p == 4 * W + 5) begin a = 24'h800000; b = 24'h800000; c = 24'd0; end
            else if (p == 4 * W + 6) begin a = 24'd1; b = 24'd1; c = 24'd1; end
            else begin
                a = DW'(((p * 3) % 11) - 5);
                b = DW'(((p * 3 + 1) % 11) - 5);
                c = DW'(((p * 3 + 2) % 11) - 5);
            end
            send_pixel(a, b, c, p == 0);
        end
        idle(12);
        frame_checks("f2", base, fd0);
        chk("f2_lit_sat_max", 64'(rec[0][base]), 64'h7FFFFF);
        chk("f2_lit_sat_min", 64'(rec[1][base + 1]), 64'h800000);
        chk("f2_lit_relu_neg", 64'(rec[2][base + 2]), 64'h0);
        chk("f2_lit_bias_neg", 64'(rec[3][base + 2]), 64'hFFFFFE);

        // Collect-side protocol errors while waiting for channel 0
        inject(3'b011);
        inject(3'b010);
        inject(3'b000);
        @(posedge clk); #1 inj_en = 1'b0;
        idle(3);
        base = tot; fd0 = nfd;
        for (int p = 0; p < W * H; p++)
            send_pixel(DW'(p * 1000 - 20000), DW'(p * 7), DW'(-p * 300), p == 0);
        idle(12);
        frame_checks("f3", base, fd0);

        // s_sof arriving mid-pixel, collect side masked
        apply_reset(3);
        inj_en = 1'b1; inj_vout = 3'b000;
        send(24'd5, 1'b1);
        send(24'd6, 1'b0);
        send(24'd7, 1'b1);
        send(24'd8, 1'b0);
        send(24'd9, 1'b0);
        send(24'd10, 1'b0);
        idle(4);

        // Reset after p0 captured, then a clean frame
        apply_reset(3);
        send(24'd1, 1'b1);
        idle(6);
        apply_reset(3);
        base = tot; fd0 = nfd;
        for (int p = 0; p < W * H; p++) send_pixel(24'd2, 24'd3, DW'(p - 40), p == 0);
        idle(12);
        frame_checks("f4", base, fd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/featuremap_sched.md
# featuremap_sched

Channel scheduler and accumulator for one feature map of the conv1 layer. It takes a pixel stream with the three input channels interleaved and issues each sample to the matching conv2d5x5 channel instance. It collects the three per-channel partial results, adds them to the bias, and applies optional ReLU with saturation. It emits only valid-window outputs, dropping the 5x5 border, and flags the last output of each frame.

## Interface
- DATA_WIDTH, 24, sample and result width, signed two's complement fixed point
- IMG_W, 32, input image width in pixels
- IMG_H, 32, input image height in pixels
- BIAS, 0, signed DATA_WIDTH-bit constant added to each channel sum
- RELU, 1, 1 = clamp negative results to 0
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_data  in  DATA_WIDTH  input sample; channel order per pixel is c0, c1, c2
- s_valid  in  1  s_data valid this cycle; no backpressure
- s_sof  in  1  qualifies s_valid; marks c0 of pixel (0,0)
- conv_data  out  DATA_WIDTH  registered sample, broadcast to all three conv instances
- conv_valid  out  3  one-hot; bit k is valid_in of channel instance k
- conv_out0, conv_out1, conv_out2  in  DATA_WIDTH each  data_out of instances 0..2
- conv_vout  in  3  valid_out of instances 0..2
- m_data  out  DATA_WIDTH  feature-map output pixel
- m_valid  out  1  m_data valid, single-cycle pulse
- frame_done  out  1  pulse with the last output of a frame
- err  out  1  sticky protocol error flag; cleared only by reset

## Operation
Conv instance contract:
- Each instance returns exactly one valid_out per valid_in, in order.
- Every instance has the same fixed latency.
- Border positions are included in the instance output stream.

Input phase FSM has three states, CH0, CH1 and CH2; the reset state is CH0.
- Each accepted s_valid drives conv_valid one-hot for the current state, then advances CH0→CH1→CH2→CH0.
- s_sof with s_valid forces channel 0 and next state CH1.
- If s_sof arrives while the state is CH1 or CH2, also set err.

Output collect FSM has three states, ACC0, ACC1 and ACC2; the reset state is ACC0.
- ACC0 accepts only conv_vout[0] and captures p0. ACC1 accepts only conv_vout[1] and captures p1. ACC2 accepts only conv_vout[2] and completes the pixel.
- A conv_vout bit that does not match the state, or more than one bit set in a cycle, sets err. The bits are ignored and the state is unchanged.

Arithmetic:
- sum = p0 + p1 + conv_out2 + BIAS, sign-extended to DATA_WIDTH+2 bits.
- If RELU is set and sum < 0, the result is 0.
- Otherwise saturate to the signed DATA_WIDTH range, max 2^(DW-1)-1 and min -2^(DW-1).

Position counters:
- col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing on each completed pixel.
- Both wrap to 0 after (IMG_W-1, IMG_H-1).
- m_valid is issued only when col ≥ 4 and row ≥ 4, giving (IMG_W-4)×(IMG_H-4) outputs per frame.
- frame_done is issued on the completed pixel at (IMG_W-1, IMG_H-1). That position is always inside the window, so it coincides with m_valid.

## Timing
Reset values:
- conv_data = 0, conv_valid = 000, m_data = 0, m_valid = 0, frame_done = 0, err = 0.
- Both FSMs start in CH0/ACC0, and col = row = 0.

Latency:
- s_valid accepted at cycle t → conv_data and conv_valid at t+1. Back-to-back s_valid is allowed every cycle.
- conv_vout[2] accepted at cycle u → m_data, m_valid and frame_done at u+1.
- All outputs are registered. The m_valid and frame_done pulses last 1 cycle.

Reset mid-operation: all state clears immediately and asynchronously. Partial p0 and p1 are discarded, and no output is produced for the interrupted pixel.

Output counters are not realigned by s_sof. Frame alignment relies on the in-order instance contract.

## Test plan
- Setup: IMG_W = IMG_H = 8, BIAS = 0, RELU = 1, with stub instances that echo the input after 3 cycles. Stream 192 samples back-to-back, s_sof on the first, all equal to 1 → conv_valid cycles 001, 010, 100; exactly 16 m_valid pulses, each m_data = 3; frame_done on the 16th pulse only; err = 0.
- Samples c0 = 0x7FFFFF, c1 = 0x7FFFFF, c2 = 1 at an in-window position → m_data = 0x7FFFFF (saturated). With RELU = 0 and c0 = c1 = 0x800000 → m_data = 0x800000.
- RELU = 1, BIAS = -5, channels 1, 1, 1 → m_data = 0. With RELU = 0 → m_data = 0xFFFFFE.
- s_sof asserted while the FSM is in CH2 → err = 1 next cycle; the sample goes to conv_valid = 001; the stream continues correctly afterwards.
- Inject conv_vout = 011 in a single cycle, then conv_vout[1] alone in ACC0 → err = 1, no m_valid, collect FSM stays in ACC0.
- Assert rst low after p0 is captured, mid-frame; release it and restart the frame with s_sof → all outputs read 0 during reset; the next frame yields exactly 16 outputs and one frame_done.
